// File: rtl/keypoint_frame_sequencer.sv
// keypoint_frame_sequencer
// Packs a byte stream of signed joint coordinates into 3-point frames.
// Buffers the frames in a small FIFO and hands them to the hierarchical
// angle/DTW scorer one at a time. Each frame is announced with a start pulse.
// The next frame is not issued until the CORDIC reports a fresh angle.
// After SEQ_LEN frames the block waits for the scorer's DTW done.

module keypoint_frame_sequencer #(
  parameter int COORD_DEPTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SEQ_LEN     = 22,
  parameter int MIN_GAP     = 22
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [COORD_DEPTH-1:0]      in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               seq_start,
  input  logic                               sample_rdy,
  input  logic                               seq_done,
  output logic signed [COORD_DEPTH-1:0]      x_0,
  output logic signed [COORD_DEPTH-1:0]      y_0,
  output logic signed [COORD_DEPTH-1:0]      x_1,
  output logic signed [COORD_DEPTH-1:0]      y_1,
  output logic signed [COORD_DEPTH-1:0]      x_2,
  output logic signed [COORD_DEPTH-1:0]      y_2,
  output logic                               start,
  output logic                               busy,
  output logic [$clog2(SEQ_LEN+1)-1:0]       frame_cnt,
  output logic                               seq_complete
);

  localparam int FRAME_W = 6 * COORD_DEPTH;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int FC_W    = $clog2(SEQ_LEN + 1);
  localparam int GAP_W   = $clog2(MIN_GAP + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ANGLE,
    WAIT_DONE
  } state_t;

  state_t state_q, state_d;

  // Assembler storage: slots 0..4 are held here.
  // Slot 5 goes straight into the FIFO.
  logic [2:0]             slot;
  logic [COORD_DEPTH-1:0] part [0:4];
  logic                   accept;
  logic                   push;
  logic [FRAME_W-1:0]     push_data;

  // FIFO storage and bookkeeping
  logic [FRAME_W-1:0]     mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FRAME_W-1:0]     rd_data;

  // Sequencer control
  logic [GAP_W-1:0]       gap_cnt;
  logic                   sample_rdy_q;
  logic                   sample_edge;
  logic                   pop;
  logic                   seq_init;
  logic                   gap_clr;
  logic                   frame_inc;
  logic                   done_pulse;

  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (count == '0);
  assign in_ready    = !((slot == 3'd5) && fifo_full);
  assign accept      = in_valid && in_ready;
  assign push        = accept && (slot == 3'd5);
  assign push_data   = {in_data, part[4], part[3], part[2], part[1], part[0]};
  assign rd_data     = mem[rd_ptr];
  assign sample_edge = sample_rdy && !sample_rdy_q;
  assign busy        = (state_q != IDLE);

  // Step the slot counter on every accepted byte.
  // It wraps after slot 5, which is the byte that completes a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= 3'd0;
    end else if (accept) begin
      if (slot == 3'd5) slot <= 3'd0;
      else              slot <= slot + 3'd1;
    end
  end

  // Capture the coordinates for slots 0..4 until the frame is complete.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (accept && (slot == 3'(i))) part[i] <= in_data;
    end
  end

  // FIFO frame storage, written when a frame is completed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Move the FIFO pointers and occupancy count.
  // A push is only possible when the FIFO is not full.
  // A pop is only possible when the FIFO is not empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register for the issue sequencer.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode.
  // Issuing waits for the settle gap to expire and a frame to be available.
  // An angle only counts on a fresh rising edge of sample_rdy.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    seq_init   = 1'b0;
    gap_clr    = 1'b0;
    frame_inc  = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_start) begin
          seq_init = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if ((gap_cnt == GAP_W'(MIN_GAP)) && !fifo_empty) begin
          pop     = 1'b1;
          state_d = WAIT_ANGLE;
        end
      end
      WAIT_ANGLE: begin
        if (sample_edge) begin
          frame_inc = 1'b1;
          if (frame_cnt == FC_W'(SEQ_LEN - 1)) begin
            state_d = WAIT_DONE;
          end else begin
            gap_clr = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      WAIT_DONE: begin
        if (seq_done) begin
          done_pulse = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer datapath: counters, the sample_rdy history and the pulses.
  // The coordinate registers hold the last popped frame until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt      <= '0;
      frame_cnt    <= '0;
      sample_rdy_q <= 1'b0;
      start        <= 1'b0;
      seq_complete <= 1'b0;
      x_0          <= '0;
      y_0          <= '0;
      x_1          <= '0;
      y_1          <= '0;
      x_2          <= '0;
      y_2          <= '0;
    end else begin
      sample_rdy_q <= sample_rdy;
      start        <= pop;
      seq_complete <= done_pulse;
      if (seq_init || gap_clr) begin
        gap_cnt <= '0;
      end else if ((state_q == ISSUE) && (gap_cnt != GAP_W'(MIN_GAP))) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (seq_init)       frame_cnt <= '0;
      else if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
      if (pop) begin
        x_0 <= rd_data[0*COORD_DEPTH +: COORD_DEPTH];
        y_0 <= rd_data[1*COORD_DEPTH +: COORD_DEPTH];
        x_1 <= rd_data[2*COORD_DEPTH +: COORD_DEPTH];
        y_1 <= rd_data[3*COORD_DEPTH +: COORD_DEPTH];
        x_2 <= rd_data[4*COORD_DEPTH +: COORD_DEPTH];
        y_2 <= rd_data[5*COORD_DEPTH +: COORD_DEPTH];
      end
    end
  end

endmodule

// File: tb/tb_keypoint_frame_sequencer.sv
// tb_keypoint_frame_sequencer
// Directed bench for the keypoint frame sequencer.
// Expected values are hand-computed for COORD_DEPTH=8, FIFO_DEPTH=4,
// SEQ_LEN=22 and MIN_GAP=22.

module tb_keypoint_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       seq_start;
  logic       sample_rdy;
  logic       seq_done;
  logic [7:0] x_0, y_0, x_1, y_1, x_2, y_2;
  logic       start;
  logic       busy;
  logic [4:0] frame_cnt;
  logic       seq_complete;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;

  keypoint_frame_sequencer #(
    .COORD_DEPTH(8),
    .FIFO_DEPTH(4),
    .SEQ_LEN(22),
    .MIN_GAP(22)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .seq_start(seq_start),
    .sample_rdy(sample_rdy),
    .seq_done(seq_done),
    .x_0(x_0),
    .y_0(y_0),
    .x_1(x_1),
    .y_1(y_1),
    .x_2(x_2),
    .y_2(y_2),
    .start(start),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .seq_complete(seq_complete)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count start pulses on the falling edge, away from the sampling point.
  always @(negedge clk) begin
    if (start === 1'b1) start_count++;
  end

  // Hard stop in case something stalls far beyond the expected runtime.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    seq_start  = 1'b0;
    sample_rdy = 1'b0;
    seq_done   = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic pulse_seq_start();
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (!in_ready) check_output("send_byte_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(b5);
  endtask

  task automatic wait_for_start(input string tag, input int limit, output int waited);
    waited = 0;
    while (!start && waited < limit) begin
      tick();
      waited++;
    end
    check_output({tag, "_start_seen"}, 32'(start), 32'd1);
  endtask

  // Drive sample_rdy like hier does.
  // The pulse starts 3 cycles after each start and lasts 5 cycles.
  task automatic respond_angles(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      wait_for_start("t4_resp", 100, w);
      repeat (3) tick();
      sample_rdy = 1'b1;
      repeat (5) tick();
      sample_rdy = 1'b0;
    end
  endtask

  task automatic feed_frames(input int n);
    for (int k = 0; k < n; k++) begin
      send_frame(8'(k*6+1), 8'(k*6+2), 8'(k*6+3), 8'(k*6+4), 8'(k*6+5), 8'(k*6+6));
    end
  endtask

  task automatic applyStimulus_dummy();
  endtask

  initial begin
    int w;
    int sc;
    int blocked_early;

    // ---- Test 1a: reset values
    apply_reset(2);
    check_output("t1_in_ready", 32'(in_ready), 32'd1);
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_start", 32'(start), 32'd0);
    check_output("t1_seq_complete", 32'(seq_complete), 32'd0);
    check_output("t1_frame_cnt", 32'(frame_cnt), 32'd0);
    check_output("t1_coords", {x_0, y_0, x_1, y_1} | {16'h0, x_2, y_2}, 32'd0);

    // ---- Test 2: single frame, start arrives 23 cycles after ISSUE entry
    send_frame(8'd70, 8'd90, 8'd60, 8'd100, 8'd50, 8'd110);
    sc = start_count;
    pulse_seq_start();
    check_output("t2_busy_after_seq_start", 32'(busy), 32'd1);
    wait_for_start("t2", 40, w);
    check_output("t2_start_latency", 32'(w), 32'd23);
    check_output("t2_x_0", 32'(x_0), 32'd70);
    check_output("t2_y_0", 32'(y_0), 32'd90);
    check_output("t2_x_1", 32'(x_1), 32'd60);
    check_output("t2_y_1", 32'(y_1), 32'd100);
    check_output("t2_x_2", 32'(x_2), 32'd50);
    check_output("t2_y_2", 32'(y_2), 32'd110);
    tick();
    check_output("t2_start_one_cycle", 32'(start), 32'd0);
    repeat (30) tick();
    check_output("t2_single_start", 32'(start_count - sc), 32'd1);
    check_output("t2_busy_held", 32'(busy), 32'd1);

    // ---- Test 1b: reset in WAIT_ANGLE with a buffered frame and a partial frame
    send_frame(8'd200, 8'd201, 8'd202, 8'd203, 8'd204, 8'd205);
    send_byte(8'd91);
    send_byte(8'd92);
    send_byte(8'd93);
    apply_reset(1);
    check_output("t1b_busy", 32'(busy), 32'd0);
    check_output("t1b_start", 32'(start), 32'd0);
    check_output("t1b_in_ready", 32'(in_ready), 32'd1);
    check_output("t1b_x_0_cleared", 32'(x_0), 32'd0);
    sc = start_count;
    pulse_seq_start();
    repeat (30) tick();
    check_output("t1b_fifo_flushed", 32'(start_count - sc), 32'd0);
    send_frame(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    wait_for_start("t1b_post", 5, w);
    check_output("t1b_pop_latency", 32'(w), 32'd1);
    check_output("t1b_x_0", 32'(x_0), 32'd1);
    check_output("t1b_y_2", 32'(y_2), 32'd6);

    // ---- Test 3: backpressure on frame 5, slot 5
    apply_reset(2);
    blocked_early = 0;
    for (int i = 0; i < 29; i++) begin
      if (!in_ready) blocked_early++;
      send_byte(8'(i + 1));
    end
    check_output("t3_no_early_block", 32'(blocked_early), 32'd0);
    in_data  = 8'd30;
    in_valid = 1'b1;
    check_output("t3_ready_low_slot5", 32'(in_ready), 32'd0);
    repeat (3) tick();
    check_output("t3_ready_stays_low", 32'(in_ready), 32'd0);
    sc = start_count;
    pulse_seq_start();
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    check_output("t3_ready_returns", 32'(in_ready), 32'd1);
    check_output("t3_ready_with_pop", 32'(start), 32'd1);
    check_output("t3_pop_latency", 32'(w), 32'd23);
    check_output("t3_x_0", 32'(x_0), 32'd1);
    tick();
    in_valid = 1'b0;
    check_output("t3_after_push_ready", 32'(in_ready), 32'd1);

    // ---- Test 4: full 22-frame sequence
    apply_reset(2);
    pulse_seq_start();
    sc = start_count;
    fork
      feed_frames(22);
      respond_angles(22);
    join
    check_output("t4_start_count", 32'(start_count - sc), 32'd22);
    check_output("t4_frame_cnt", 32'(frame_cnt), 32'd22);
    check_output("t4_busy_wait_done", 32'(busy), 32'd1);
    repeat (30) tick();
    check_output("t4_no_extra_start", 32'(start_count - sc), 32'd22);
    check_output("t4_last_x_0", 32'(x_0), 32'd127);
    check_output("t4_last_y_2", 32'(y_2), 32'h84);
    check_output("t4_no_early_complete", 32'(seq_complete), 32'd0);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    check_output("t4_seq_complete", 32'(seq_complete), 32'd1);
    check_output("t4_idle", 32'(busy), 32'd0);
    tick();
    check_output("t4_seq_complete_pulse", 32'(seq_complete), 32'd0);
    check_output("t4_frame_cnt_held", 32'(frame_cnt), 32'd22);

    // ---- Test 5: sample_rdy level carried over is ignored
    apply_reset(2);
    send_frame(8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16);
    send_frame(8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26);
    sample_rdy = 1'b1;
    repeat (2) tick();
    sc = start_count;
    pulse_seq_start();
    wait_for_start("t5_first", 40, w);
    check_output("t5_first_x_0", 32'(x_0), 32'd11);
    repeat (10) tick();
    check_output("t5_level_ignored", 32'(frame_cnt), 32'd0);
    sample_rdy = 1'b0;
    repeat (2) tick();
    sample_rdy = 1'b1;
    tick();
    check_output("t5_first_edge", 32'(frame_cnt), 32'd1);
    wait_for_start("t5_second", 40, w);
    check_output("t5_second_x_0", 32'(x_0), 32'd21);
    repeat (10) tick();
    check_output("t5_held_high", 32'(frame_cnt), 32'd1);
    sample_rdy = 1'b0;
    repeat (2) tick();
    sample_rdy = 1'b1;
    tick();
    check_output("t5_second_edge", 32'(frame_cnt), 32'd2);
    check_output("t5_start_count", 32'(start_count - sc), 32'd2);
    sample_rdy = 1'b0;

    // ---- Test 6: extreme signed values and ignored second seq_start
    apply_reset(2);
    send_frame(8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h80, 8'h7F);
    pulse_seq_start();
    wait_for_start("t6", 40, w);
    check_output("t6_x_0", 32'(x_0), 32'h80);
    check_output("t6_y_0", 32'(y_0), 32'hFF);
    check_output("t6_x_1", 32'(x_1), 32'h7F);
    check_output("t6_y_1", 32'(y_1), 32'hFF);
    check_output("t6_x_2", 32'(x_2), 32'h80);
    check_output("t6_y_2", 32'(y_2), 32'h7F);
    sample_rdy = 1'b1;
    tick();
    sample_rdy = 1'b0;
    check_output("t6_frame_cnt_one", 32'(frame_cnt), 32'd1);
    pulse_seq_start();
    check_output("t6_second_start_ignored", 32'(frame_cnt), 32'd1);
    check_output("t6_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check_output("t6_frame_cnt_stable", 32'(frame_cnt), 32'd1);
    check_output("t6_coords_held", 32'(x_0), 32'h80);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
